lc3_run_ctrl: RTL and testbench

Parametrised clock-enable and run-control generator for the LC-3 system. From the single board clock it produces a stretched CPU reset, a gated CPU clock-enable with programmable division, free-running peripheral clock-enables, and a run/halt/single-step debug FSM. It sits between the top-level clock/reset pins and the `LC3` core, replacing the bare free-running clock drive.

---
 rtl/lc3_pkg.sv | 21 ++
 rtl/lc3_ce_div.sv | 45 ++++
 rtl/lc3_run_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_lc3_run_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lc3_pkg
// Description : Shared definitions for the LC-3 run-control block.
//               - run_state_t : run/halt/step FSM state encoding
//               - CYCLE_CNT_W : width of the CPU enable-pulse counter
// Revision    : 1.0 - initial release
// ============================================================================
package lc3_pkg;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_HALT  = 2'd1,
    ST_RUN   = 2'd2,
    ST_STEP  = 2'd3
  } run_state_t;

  localparam int CYCLE_CNT_W = 32;

endpackage
`default_nettype wire

// File: rtl/lc3_ce_div.sv
`default_nettype none
// ============================================================================
// Module      : lc3_ce_div
// Description : Free-running clock-enable divider. The tick is asserted
//               whenever the count has reached the divisor D, giving one tick
//               every D+1 edges. The tick output is combinational; the parent
//               registers it.
// Ports       : clk    - system clock (rising edge)
//               rst_n  - asynchronous active-low reset
//               div_i  - divisor D, sampled every edge
//               tick_o - divider tick (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module lc3_ce_div
  import lc3_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] r_cnt;
  logic             w_tick;

  // '>=' rather than '==' so that lowering D below the current count reloads
  // at once instead of letting the counter run round through zero.
  assign w_tick = (r_cnt >= div_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick_o = w_tick;

endmodule
`default_nettype wire

// File: rtl/lc3_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lc3_run_ctrl
// Description : Clock-enable and run-control generator for the LC-3 system.
//               Produces a stretched CPU reset, a gated CPU clock-enable
//               (channel 0), free-running peripheral enables (channels 1..),
//               and a RESET/HALT/RUN/STEP debug FSM.
// Ports       : clk         - system clock (rising edge)
//               rst_n       - asynchronous active-low reset
//               div_i       - per-channel divisors, channel k at [k*DIV_W +: DIV_W]
//               run_i       - rising edge requests RUN
//               halt_i      - level, forces HALT and blocks the CPU enable
//               step_i      - rising edge requests one CPU enable while halted
//               cpu_rst_n_o - stretched active-low CPU reset
//               ce_o        - registered one-cycle clock-enable pulses
//               state_o     - FSM state (RESET=0, HALT=1, RUN=2, STEP=3)
//               cycle_cnt_o - number of ce_o[0] pulses emitted
// Options     : LC3_RUN_CTRL_CYCLE_CNT_EN - build the 32-bit cycle counter;
//               when undefined cycle_cnt_o is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module lc3_run_ctrl
  import lc3_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 8,
  parameter int RST_STRETCH = 16,
  parameter int BOOT_RUN    = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*DIV_W-1:0] div_i,
  input  logic                    run_i,
  input  logic                    halt_i,
  input  logic                    step_i,
  output logic                    cpu_rst_n_o,
  output logic [NUM_CH-1:0]       ce_o,
  output logic [1:0]              state_o,
  output logic [CYCLE_CNT_W-1:0]  cycle_cnt_o
);

  localparam int c_STRETCH_W = (RST_STRETCH < 2) ? 1 : $clog2(RST_STRETCH + 1);
  localparam logic [c_STRETCH_W-1:0] c_STRETCH_LAST = c_STRETCH_W'(RST_STRETCH - 1);

  run_state_t              r_state;
  run_state_t              w_state_nxt;
  logic [c_STRETCH_W-1:0]  r_stretch;
  logic                    r_cpu_rst_n;
  logic [NUM_CH-1:0]       r_ce;
  logic [NUM_CH-1:0]       w_ce_nxt;
  logic [NUM_CH-1:0]       w_tick;
  logic                    w_ce0_nxt;
  logic                    r_run_sync;
  logic                    r_run_prev;
  logic                    r_step_sync;
  logic                    r_step_prev;
  logic                    w_run_rise;
  logic                    w_step_rise;

  // --------------------------------------------------------------------------
  // Per-channel dividers
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < NUM_CH; k++) begin : g_div
    lc3_ce_div #(
      .DIV_W (DIV_W)
    ) u_div (
      .clk    (clk),
      .rst_n  (rst_n),
      .div_i  (div_i[k*DIV_W +: DIV_W]),
      .tick_o (w_tick[k])
    );
  end

  // --------------------------------------------------------------------------
  // Request edge detection: one synchronising stage, then a history stage,
  // so a request reaches the FSM one edge after the input rises.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run_sync  <= 1'b0;
      r_run_prev  <= 1'b0;
      r_step_sync <= 1'b0;
      r_step_prev <= 1'b0;
    end else begin
      r_run_sync  <= run_i;
      r_run_prev  <= r_run_sync;
      r_step_sync <= step_i;
      r_step_prev <= r_step_sync;
    end
  end

  assign w_run_rise  = r_run_sync  & ~r_run_prev;
  assign w_step_rise = r_step_sync & ~r_step_prev;

  // --------------------------------------------------------------------------
  // FSM state register and reset stretch counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RESET;
      r_stretch   <= '0;
      r_cpu_rst_n <= 1'b0;
      r_ce        <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cpu_rst_n <= (r_state != ST_RESET);
      r_ce        <= w_ce_nxt;
      if (r_state == ST_RESET) begin
        r_stretch <= r_stretch + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and channel-0 gating. The CPU enable is qualified by the
  // state held before the edge, so the pulse that accompanies the move from
  // STEP to HALT is still emitted.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_ce0_nxt   = 1'b0;

    case (r_state)
      ST_RESET: begin
        if (r_stretch == c_STRETCH_LAST) begin
          w_state_nxt = (BOOT_RUN != 0) ? ST_RUN : ST_HALT;
        end
      end
      ST_HALT: begin
        if (w_step_rise) begin
          w_state_nxt = ST_STEP;
        end else if (w_run_rise) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_ce0_nxt = w_tick[0];
      end
      ST_STEP: begin
        if (w_tick[0]) begin
          w_ce0_nxt   = 1'b1;
          w_state_nxt = ST_HALT;
        end
      end
      default: begin
        w_state_nxt = ST_RESET;
      end
    endcase

    // halt_i overrides everything once out of RESET, including the pulse.
    if (halt_i && (r_state != ST_RESET)) begin
      w_state_nxt = ST_HALT;
      w_ce0_nxt   = 1'b0;
    end

    w_ce_nxt    = w_tick;
    w_ce_nxt[0] = w_ce0_nxt;
  end

  // --------------------------------------------------------------------------
  // Cycle counter: advances on the same edge that sets ce_o[0], so it always
  // equals the number of CPU enable pulses emitted so far.
  // --------------------------------------------------------------------------
`ifdef LC3_RUN_CTRL_CYCLE_CNT_EN
  logic [CYCLE_CNT_W-1:0] r_cycle_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_cnt <= '0;
    end else if (w_ce_nxt[0]) begin
      r_cycle_cnt <= r_cycle_cnt + 1'b1;
    end
  end

  assign cycle_cnt_o = r_cycle_cnt;
`else
  assign cycle_cnt_o = '0;
`endif

  assign cpu_rst_n_o = r_cpu_rst_n;
  assign ce_o        = r_ce;
  assign state_o     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_lc3_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lc3_run_ctrl
// Description : Directed self-checking bench for lc3_run_ctrl. Instance dut
//               boots to RUN (stretch 16), instance dut_b boots to HALT
//               (stretch 4) and carries the step, divisor-change and
//               mid-STEP reset scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lc3_run_ctrl;

`ifdef LC3_RUN_CTRL_CYCLE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk;
  // dut: BOOT_RUN=1, RST_STRETCH=16
  logic        rst_n;
  logic [15:0] div;
  logic        run;
  logic        halt;
  logic        step;
  logic        cpu_rst_n;
  logic [1:0]  ce;
  logic [1:0]  state;
  logic [31:0] cyc;
  // dut_b: BOOT_RUN=0, RST_STRETCH=4
  logic        rst_b_n;
  logic [15:0] div_b;
  logic        run_b;
  logic        halt_b;
  logic        step_b;
  logic        cpu_rst_b_n;
  logic [1:0]  ce_b;
  logic [1:0]  state_b;
  logic [31:0] cyc_b;

  int n_pass  = 0;
  int n_total = 0;
  int pulses;

  lc3_run_ctrl #(
    .NUM_CH(2), .DIV_W(8), .RST_STRETCH(16), .BOOT_RUN(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .div_i(div), .run_i(run), .halt_i(halt),
    .step_i(step), .cpu_rst_n_o(cpu_rst_n), .ce_o(ce), .state_o(state),
    .cycle_cnt_o(cyc)
  );

  lc3_run_ctrl #(
    .NUM_CH(2), .DIV_W(8), .RST_STRETCH(4), .BOOT_RUN(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_b_n), .div_i(div_b), .run_i(run_b), .halt_i(halt_b),
    .step_i(step_b), .cpu_rst_n_o(cpu_rst_b_n), .ce_o(ce_b), .state_o(state_b),
    .cycle_cnt_o(cyc_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    rst_n = 1'b0; rst_b_n = 1'b0;
    run = 1'b0; halt = 1'b0; step = 1'b0;
    run_b = 1'b0; halt_b = 1'b0; step_b = 1'b0;
    div   = {8'd3, 8'd0};   // ch1 D=3, ch0 D=0
    div_b = {8'd7, 8'd3};   // ch1 D=7, ch0 D=3
    adv(3);

    // ---- reset values ----
    chk("rst_state", 32'(state), 0);
    chk("rst_cpu_rst_n", 32'(cpu_rst_n), 0);
    chk("rst_ce", 32'(ce), 0);
    chk("rst_cyc", cyc, 0);

    // ---- boot to RUN: edges counted from reset release ----
    rst_n = 1'b1;
    for (int e = 1; e <= 26; e++) begin
      adv(1);
      chk($sformatf("boot_state_e%0d", e), 32'(state), (e >= 16) ? 2 : 0);
      chk($sformatf("boot_cpu_rst_n_e%0d", e), 32'(cpu_rst_n), (e >= 17) ? 1 : 0);
      chk($sformatf("boot_ce0_e%0d", e), 32'(ce[0]), (e >= 17) ? 1 : 0);
      chk($sformatf("ch1_div3_e%0d", e), 32'(ce[1]), (e % 4 == 0) ? 1 : 0);
    end
    chk("boot_cyc10", cyc, CNT_EN ? 10 : 0);

    // ---- halt during RUN: one edge latency, pulse suppressed ----
    halt = 1'b1;
    adv(1);
    chk("halt_state", 32'(state), 1);
    chk("halt_ce0", 32'(ce[0]), 0);
    adv(3);
    chk("halt_hold_state", 32'(state), 1);
    chk("halt_hold_ce0", 32'(ce[0]), 0);
    chk("halt_cyc", cyc, CNT_EN ? 10 : 0);
    halt = 1'b0;
    adv(2);
    chk("halt_release_state", 32'(state), 1);

    // ---- run request: RUN two edges after the rise ----
    run = 1'b1;
    adv(1);
    chk("run_lat1_state", 32'(state), 1);
    adv(1);
    chk("run_lat2_state", 32'(state), 2);
    chk("run_lat2_ce0", 32'(ce[0]), 0);
    run = 1'b0;
    adv(1);
    chk("run_ce0", 32'(ce[0]), 1);
    chk("run_cyc", cyc, CNT_EN ? 11 : 0);

    // ---- step rise in RUN is ignored ----
    step = 1'b1;
    adv(1);
    step = 1'b0;
    adv(3);
    chk("run_step_ignored", 32'(state), 2);
    chk("run_step_ce0", 32'(ce[0]), 1);

    // ---- dut_b: boot to HALT, ch1 divisor 7 -> 2 while cnt=5 ----
    rst_b_n = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      adv(1);
      chk($sformatf("b_state_e%0d", e), 32'(state_b), (e >= 4) ? 1 : 0);
      chk($sformatf("b_cpu_rst_n_e%0d", e), 32'(cpu_rst_b_n), (e >= 5) ? 1 : 0);
      chk($sformatf("b_ch1_e%0d", e), 32'(ce_b[1]), (e == 6 || e == 9 || e == 12) ? 1 : 0);
      chk($sformatf("b_ce0_e%0d", e), 32'(ce_b[0]), 0);
      if (e == 5) div_b[15:8] = 8'd2;
    end

    // ---- three single steps, D0=3 ----
    for (int s = 0; s < 3; s++) begin
      step_b = 1'b1;
      adv(1);
      step_b = 1'b0;
      chk($sformatf("step%0d_lat1", s), 32'(state_b), 1);
      adv(1);
      chk($sformatf("step%0d_enter", s), 32'(state_b), 3);
      pulses = 0;
      for (int i = 0; i < 18; i++) begin
        adv(1);
        if (ce_b[0] === 1'b1) pulses++;
      end
      chk($sformatf("step%0d_pulses", s), 32'(pulses), 1);
      chk($sformatf("step%0d_back_halt", s), 32'(state_b), 1);
    end
    chk("step_cyc3", cyc_b, CNT_EN ? 3 : 0);

    // ---- asynchronous reset mid-STEP ----
    step_b = 1'b1;
    adv(1);
    step_b = 1'b0;
    adv(1);
    chk("midstep_state", 32'(state_b), 3);
    rst_b_n = 1'b0;
    #1;
    chk("areset_state", 32'(state_b), 0);
    chk("areset_cpu_rst_n", 32'(cpu_rst_b_n), 0);
    chk("areset_ce", 32'(ce_b), 0);
    chk("areset_cyc", cyc_b, 0);
    @(posedge clk);
    #1;
    rst_b_n = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      adv(1);
      chk($sformatf("rerel_state_e%0d", e), 32'(state_b), (e >= 4) ? 1 : 0);
      chk($sformatf("rerel_cpu_rst_n_e%0d", e), 32'(cpu_rst_b_n), (e >= 5) ? 1 : 0);
    end

    // ---- cycle counter wrap ----
`ifdef LC3_RUN_CTRL_CYCLE_CNT_EN
    force dut_b.r_cycle_cnt = 32'hFFFF_FFFF;
    adv(1);
    release dut_b.r_cycle_cnt;
    adv(1);
    chk("wrap_preload", cyc_b, 32'hFFFF_FFFF);
`endif
    step_b = 1'b1;
    adv(1);
    step_b = 1'b0;
    adv(20);
    chk("wrap_state", 32'(state_b), 1);
    chk("wrap_cyc", cyc_b, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
